wm8731_i2c_responder: RTL
=========================

Name: wm8731_i2c_responder

Overview:
Synthesizable I2C write-only responder that models the WM8731 codec's 2-wire control port. It is the far end of the Nios system's i2c_SCLK/i2c_SDAT configuration master. It decodes 3-byte register writes (7-bit reg address + 9-bit data) into a shadow register file with WM8731 reset defaults. It is used as an on-board/loopback codec model and as the self-checking target in the audio config bench.

Parameters:
DEV_ADDR, 7'h1A, 7-bit slave address (0x34 write byte).
SYNC_STAGES, 2, synchronizer depth on SCL/SDA inputs (2..3).
RST_REG, 7'h0F, register address whose write restores all defaults.

Ports:
clk_clk  input  1  system clock, >=10x SCL frequency
reset_reset_n  input  1  asynchronous active-low reset
i2c_SCLK  input  1  I2C clock from master
i2c_SDAT_in  input  1  I2C data line sampled value
i2c_SDAT_oe  output  1  1 = pull SDA low (open-drain; top level ties pad to 0 when set)
reg_wr_valid  output  1  one-cycle pulse on committed register write
reg_wr_addr  output  7  register address of committed write
reg_wr_data  output  9  data of committed write
rd_addr  input  4  shadow register read index
rd_data  output  9  shadow register contents, combinational from rd_addr
busy  output  1  high from START until STOP, or until IDLE/IGNORE entry
err  output  1  one-cycle pulse: write to unimplemented register (10..14 or >15)

Behaviour:
- Reset values: i2c_SDAT_oe=0, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, busy=0, err=0, state IDLE, sync flops=1.
- Shadow regs R0..R9 defaults: 097,097,079,079,00A,008,09F,00A,000,000 (hex). rd_addr >=10 returns 0.
- SCL and SDA pass through SYNC_STAGES flops, then are edge-detected on clk_clk.
- START: sync SDA falls while SCL high. STOP: sync SDA rises while SCL high.
- Data bits are sampled on the SCL rising edge, MSB first.
- SDA_oe changes only on the SCL falling edge.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP, IGNORE.
- START from any state: go to ADDR, clear the bit counter, drop oe, set busy.
- STOP from any state: go to IDLE, drop oe, clear busy. A pending partial write is discarded.
- ADDR: shift 8 bits. On the 8th SCL fall:
  - if addr==DEV_ADDR and R/W=0: set oe=1, go to ACK_A;
  - otherwise (mismatch or read): oe stays 0 (NACK), go to IGNORE.
- ACK_A / ACK_1: on the next SCL fall, release oe and go to BYTE1 / BYTE2.
- BYTE1 / BYTE2: shift 8 bits. On the 8th SCL fall, set oe=1 (ACK) and advance to the next ACK state.
- ACK_2: on its SCL fall, release oe and go to WAIT_STOP. On the same clk, commit:
  - addr = byte1[7:1], data = {byte1[0], byte2};
  - pulse reg_wr_valid with reg_wr_addr/reg_wr_data.
- Commit rules:
  - addr 0..9: update that shadow register;
  - addr==RST_REG: reload all defaults (reg_wr_valid still pulses);
  - any other addr: no update, pulse err, valid still pulses.
- WAIT_STOP: further bytes are NACKed (oe never set) and ignored. Only STOP or START leaves this state.
- IGNORE: never drive SDA; exit only on STOP or START.
- Repeated START after a commit behaves like a fresh transaction; the commit stands.
- Reset asserted mid-transfer: immediate return to reset values, oe released the same instant (async), registers reloaded to defaults.
- Glitch rule: SCL/SDA edges are judged only after synchronization. No filtering beyond SYNC_STAGES is required.
- Latency: reg_wr_valid occurs SYNC_STAGES+1 clk after the raw SCL falling edge ending the third ACK. rd_data reflects the update on the following clk.

Decomposition:
- Package wm8731_pkg: state enum; DEFAULT_REGS array constant (10x9 bits); WM8731_DEV_ADDR=7'h1A; WM8731_RST_REG=7'h0F; NUM_SHADOW_REGS=10.
- Sub-module i2c_line_sync: synchronizers plus scl_rise, scl_fall, start_det, stop_det outputs. It is reused by any future I2C responder.

Test Plan:
- Reset released -> oe=0, valid=0, busy=0; rd_addr=0 gives 0x097, rd_addr=6 gives 0x09F, rd_addr=12 gives 0x000.
- START, 0x34, 0x08, 0x12, STOP at 100 kHz (clk 50 MHz) -> three ACK bits low; one valid pulse with addr=4, data=0x012; then rd R4=0x012.
- START, 0x36, 0x08, 0x12, STOP -> all ACK slots high (oe never 1); no valid; R4 unchanged. Repeat with 0x35 (read) -> same result.
- Write R7=0x1FF (bytes 0x0F,0xFF), then write RST_REG (bytes 0x1E,0x00) -> R7 back to 0x00A; valid pulses twice; err never pulses.
- START, 0x34, 0x04, STOP (no byte2) -> no valid, no change. Then START, 0x34, 0x04, repeated START, 0x34, 0x05, 0xFF, STOP -> only R2=0x1FF committed.
- Write bytes 0x18,0x55 (addr 12) -> valid + err pulse, no reg change. A fourth byte after any commit is NACKed. reset_reset_n low during BYTE1 with oe high -> oe drops asynchronously.

Source files
------------

// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 control-port responder.
// Holds the FSM state encoding and the codec's power-on register image.
package wm8731_pkg;

   localparam logic [6:0]  WM8731_DEV_ADDR = 7'h1A;
   localparam logic [6:0]  WM8731_RST_REG  = 7'h0F;
   localparam int unsigned NUM_SHADOW_REGS = 10;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_A,
      ST_BYTE1,
      ST_ACK_1,
      ST_BYTE2,
      ST_ACK_2,
      ST_WAIT_STOP,
      ST_IGNORE
   } state_t;

   localparam logic [8:0] DEFAULT_REGS [NUM_SHADOW_REGS] = '{
      9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
      9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
   };

endpackage

// File: rtl/wm8731_i2c_responder_line_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP condition detection.
// Reusable front end for any I2C responder clocked well above SCL.
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_ff;
   logic [SYNC_STAGES-1:0] sda_ff;
   logic                   scl_d;
   logic                   sda_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_ff <= '1;
         sda_ff <= '1;
         scl_d  <= 1'b1;
         sda_d  <= 1'b1;
      end else begin
         scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_in};
         sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_in};
         scl_d  <= scl_ff[SYNC_STAGES-1];
         sda_d  <= sda_ff[SYNC_STAGES-1];
      end
   end

   assign scl       = scl_ff[SYNC_STAGES-1];
   assign sda       = sda_ff[SYNC_STAGES-1];
   assign scl_rise  =  scl & ~scl_d;
   assign scl_fall  = ~scl &  scl_d;
   // SDA transitions only count as START/STOP while SCL is steadily high
   assign start_det =  scl & scl_d & sda_d & ~sda;
   assign stop_det  =  scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// Write-only I2C responder modelling the WM8731 control port.
// Decodes 3-byte register writes into a shadow register file with codec defaults.
module wm8731_i2c_responder
   import wm8731_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = WM8731_DEV_ADDR,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [6:0]  RST_REG     = WM8731_RST_REG
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic       i2c_SCLK,
   input  logic       i2c_SDAT_in,
   output logic       i2c_SDAT_oe,
   output logic       reg_wr_valid,
   output logic [6:0] reg_wr_addr,
   output logic [8:0] reg_wr_data,
   input  logic [3:0] rd_addr,
   output logic [8:0] rd_data,
   output logic       busy,
   output logic       err
);

   localparam logic [6:0] NUM_REGS_A = 7'(NUM_SHADOW_REGS);
   localparam logic [3:0] NUM_REGS_R = 4'(NUM_SHADOW_REGS);

   logic       scl, sda, scl_rise, scl_fall, start_det, stop_det;
   state_t     state, state_n;
   logic [3:0] bit_cnt, bit_cnt_n;
   logic [7:0] shift, shift_n;
   logic [7:0] byte1, byte1_n;
   logic       oe_n, busy_n, commit;
   logic [6:0] commit_addr;
   logic [8:0] commit_data;
   logic [8:0] regs [NUM_SHADOW_REGS];

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .scl_in    (i2c_SCLK),
      .sda_in    (i2c_SDAT_in),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         byte1       <= '0;
         i2c_SDAT_oe <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         shift       <= shift_n;
         byte1       <= byte1_n;
         i2c_SDAT_oe <= oe_n;
         busy        <= busy_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      byte1_n   = byte1;
      oe_n      = i2c_SDAT_oe;
      busy_n    = busy;
      commit    = 1'b0;
      if (start_det) begin
         state_n   = ST_ADDR;
         bit_cnt_n = '0;
         oe_n      = 1'b0;
         busy_n    = 1'b1;
      end else if (stop_det) begin
         state_n = ST_IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else begin
         case (state)
            ST_ADDR, ST_BYTE1, ST_BYTE2: begin
               if (scl_rise && bit_cnt != 4'd8) begin
                  shift_n   = {shift[6:0], sda};
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt_n = '0;
                  if (state == ST_ADDR) begin
                     if (shift[7:1] == DEV_ADDR && !shift[0]) begin
                        oe_n    = 1'b1;
                        state_n = ST_ACK_A;
                     end else begin
                        state_n = ST_IGNORE;
                        busy_n  = 1'b0;
                     end
                  end else if (state == ST_BYTE1) begin
                     byte1_n = shift;
                     oe_n    = 1'b1;
                     state_n = ST_ACK_1;
                  end else begin
                     oe_n    = 1'b1;
                     state_n = ST_ACK_2;
                  end
               end
            end
            ST_ACK_A, ST_ACK_1: begin
               if (scl_fall) begin
                  oe_n      = 1'b0;
                  bit_cnt_n = '0;
                  state_n   = (state == ST_ACK_A) ? ST_BYTE1 : ST_BYTE2;
               end
            end
            ST_ACK_2: begin
               if (scl_fall) begin
                  oe_n    = 1'b0;
                  state_n = ST_WAIT_STOP;
                  commit  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // shift still holds the second data byte while in ACK_2
   assign commit_addr = byte1[7:1];
   assign commit_data = {byte1[0], shift};

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         reg_wr_valid <= 1'b0;
         reg_wr_addr  <= '0;
         reg_wr_data  <= '0;
         err          <= 1'b0;
         for (int unsigned i = 0; i < NUM_SHADOW_REGS; i++) regs[i] <= DEFAULT_REGS[i];
      end else begin
         reg_wr_valid <= commit;
         err          <= commit && commit_addr >= NUM_REGS_A && commit_addr != RST_REG;
         if (commit) begin
            reg_wr_addr <= commit_addr;
            reg_wr_data <= commit_data;
            if (commit_addr < NUM_REGS_A)
               regs[commit_addr[3:0]] <= commit_data;
            else if (commit_addr == RST_REG)
               for (int unsigned i = 0; i < NUM_SHADOW_REGS; i++) regs[i] <= DEFAULT_REGS[i];
         end
      end
   end

   assign rd_data = (rd_addr < NUM_REGS_R) ? regs[rd_addr] : '0;

endmodule
